// File: rtl/repadd_pkg.sv
// rtl/repadd_pkg.sv - shared types and constants for the repeated-addition multiplier
package repadd_pkg;

    // Operand / datapath width; the controller and datapath must agree on it.
    localparam int REPADD_WIDTH = 16;

    // Controller state encoding.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        ADD    = 3'd3,
        DONE   = 3'd4
    } repadd_state_e;

endpackage

// File: rtl/repadd_ctrl.sv
// rtl/repadd_ctrl.sv - control FSM sequencing the repeated-addition multiplier datapath
module repadd_ctrl
    import repadd_pkg::*;
#(
    parameter int WIDTH = REPADD_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    input  logic             din_vld,
    input  logic             eqz,
    output logic             ldA,
    output logic             ldB,
    output logic             clrP,
    output logic             ldP,
    output logic             decB,
    output logic             busy,
    output logic             done
);

    repadd_state_e r_state;
    repadd_state_e w_next;
    logic          w_din_zero;

    assign w_din_zero = (din == '0);

    // State register; reset aborts any operation in flight and returns to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and strobe decode; all outputs are pure functions of state and live inputs.
    always_comb begin
        w_next = r_state;
        ldA    = 1'b0;
        ldB    = 1'b0;
        clrP   = 1'b0;
        ldP    = 1'b0;
        decB   = 1'b0;
        busy   = 1'b1;
        done   = 1'b0;
        unique case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_next = LOAD_A;
                end
            end
            LOAD_A: begin
                ldA = din_vld;
                if (din_vld) begin
                    w_next = LOAD_B;
                end
            end
            LOAD_B: begin
                // Accumulator is cleared in the same cycle B is captured.
                ldB  = din_vld;
                clrP = din_vld;
                if (din_vld) begin
                    w_next = w_din_zero ? DONE : ADD;
                end
            end
            ADD: begin
                // The final add leaves B at 1 rather than decrementing to 0.
                ldP  = 1'b1;
                decB = ~eqz;
                if (eqz) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_repadd_ctrl.sv
// tb/tb_repadd_ctrl.sv - directed self-checking bench for repadd_ctrl with a behavioural datapath
module tb_repadd_ctrl;

    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] din;
    logic         din_vld;
    logic         eqz;
    logic         ldA, ldB, clrP, ldP, decB, busy, done;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural datapath: A register, B down-counter, P accumulator.
    logic [W-1:0] dp_a, dp_b, dp_p;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           sa;
        int           sb;
        logic [W-1:0] exp_p;
        int           exp_done;
        int           exp_ldp;
        int           exp_decb;
    } vec_t;

    vec_t vecs [5];

    repadd_ctrl #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .din    (din),
        .din_vld(din_vld),
        .eqz    (eqz),
        .ldA    (ldA),
        .ldB    (ldB),
        .clrP   (clrP),
        .ldP    (ldP),
        .decB   (decB),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ldA) dp_a <= din;
        if (ldB) dp_b <= din;
        else if (decB) dp_b <= dp_b - 1'b1;
        if (clrP) dp_p <= '0;
        else if (ldP) dp_p <= dp_p + dp_a;
    end
    assign eqz = (dp_b == 16'd1);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] outs();
        return {ldA, ldB, clrP, ldP, decB, busy, done};
    endfunction

    // Runs one multiplication; cycle c is the clock period after edge c-1, start sampled at edge 0.
    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int sa, input int sb, input logic hold,
                          input logic [W-1:0] exp_p, input int exp_done,
                          input int exp_ldp, input int exp_decb);
        int first_lda = -1;
        int n_lda = 0;
        int ldb_cyc = -1;
        int n_ldb = 0;
        int n_ldp = 0;
        int n_decb = 0;
        int done_cyc = -1;
        int bad = 0;
        logic [W-1:0] p_done = '0;
        start   = 1'b1;
        din_vld = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk);
            #1;
            start = hold;
            if (c == sa + 1) begin
                din = a; din_vld = 1'b1;
            end else if (c == sa + sb + 2) begin
                din = b; din_vld = 1'b1;
            end else begin
                din = W'($urandom); din_vld = 1'b0;
            end
            @(negedge clk);
            if (ldA) begin
                n_lda++;
                if (first_lda < 0) first_lda = c;
            end
            if (ldB) begin
                n_ldb++;
                ldb_cyc = c;
            end
            if (ldP) n_ldp++;
            if (decB) n_decb++;
            if ((int'(ldA) + int'(ldB) + int'(ldP)) > 1) bad++;
            if (clrP != ldB) bad++;
            if (!busy) bad++;
            if (done) begin
                done_cyc = c;
                p_done   = dp_p;
                break;
            end
        end
        check({name, " done cycle"}, done_cyc, exp_done);
        check({name, " ldA cycle"}, first_lda, sa + 1);
        check({name, " ldA count"}, n_lda, 1);
        check({name, " ldB cycle"}, ldb_cyc, sa + sb + 2);
        check({name, " ldB count"}, n_ldb, 1);
        check({name, " ldP count"}, n_ldp, exp_ldp);
        check({name, " decB count"}, n_decb, exp_decb);
        check({name, " strobe consistency"}, bad, 0);
        check({name, " P at done"}, p_done, exp_p);
        @(posedge clk);
        #1;
        start   = hold;
        din_vld = 1'b0;
        @(negedge clk);
        check({name, " outputs after done"}, outs(), 7'b0);
        check({name, " P held"}, dp_p, exp_p);
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        din     = '0;
        din_vld = 1'b0;

        vecs[0] = '{16'd7,    16'd5, 0, 0, 16'd35,   8,  5, 4};
        vecs[1] = '{16'd9,    16'd1, 0, 0, 16'd9,    4,  1, 0};
        vecs[2] = '{16'd9,    16'd0, 0, 0, 16'd0,    3,  0, 0};
        vecs[3] = '{16'd3,    16'd4, 2, 3, 16'd12,   12, 4, 3};
        vecs[4] = '{16'hFFFF, 16'd2, 0, 0, 16'hFFFE, 5,  2, 1};

        // Reset state, including start asserted while in reset.
        #3;
        check("reset outputs", outs(), 7'b0);
        start = 1'b1;
        @(posedge clk);
        #1;
        check("reset outputs with start", outs(), 7'b0);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle after reset", outs(), 7'b0);

        for (int i = 0; i < 5; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sa, vecs[i].sb, 1'b0,
                   vecs[i].exp_p, vecs[i].exp_done, vecs[i].exp_ldp, vecs[i].exp_decb);
        end

        // Reset during the third ADD cycle (cycle 5) of A=7, B=5.
        start   = 1'b1;
        din_vld = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (c == 1) begin
                din = 16'd7; din_vld = 1'b1;
            end else if (c == 2) begin
                din = 16'd5; din_vld = 1'b1;
            end else begin
                din_vld = 1'b0;
            end
            @(negedge clk);
        end
        check("pre-reset ldP", ldP, 1'b1);
        check("pre-reset P", dp_p, 16'd14);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset outputs", outs(), 7'b0);
        @(posedge clk);
        #1;
        check("held reset outputs", outs(), 7'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle after mid reset", outs(), 7'b0);
        run_op("post-reset", 16'd2, 16'd3, 0, 0, 1'b0, 16'd6, 6, 3, 2);

        // Start held high across two back-to-back runs.
        run_op("hold run1", 16'd4, 16'd4, 0, 0, 1'b1, 16'd16, 7, 4, 3);
        run_op("hold run2", 16'd5, 16'd6, 0, 0, 1'b1, 16'd30, 9, 6, 5);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global timeout: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
